pipeline_hazard_arbiter: RTL
============================

# pipeline_hazard_arbiter

Parametrised successor to the fixed five-stage hazard controller. It resolves per-stage stall requests and multi-source PC redirects into per-pipeline-register stall/flush controls and a single PC load. A redirect that cannot fire is held internally until the pipeline allows it. The block also keeps saturating hazard event counters and a stall watchdog, and sits between the pipeline stages and the `pc_ifc`/`load_pc_ifc` logic of `mips_core`.

## Interface
- `NUM_STAGES`, 5: pipeline stages, ≥3. Stage 0 = IF, stage N-1 = last stallable stage.
- `ADDR_WIDTH`, 32: PC width.
- `CNT_WIDTH`, 16: event counter width.
- `WDOG_LIMIT`, 1024: consecutive front-end stall cycles that trip the watchdog.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall_req`  in  NUM_STAGES  stage i cannot complete its instruction this cycle.
- `redirect_valid`  in  NUM_STAGES  stage i requests refetch (jump or mispredict). Bit 0 is ignored.
- `redirect_target`  in  NUM_STAGES*ADDR_WIDTH  target for stage i, in slice i.
- `stall`  out  NUM_STAGES  hold the input register of stage i (stall[0] holds the PC).
- `flush`  out  NUM_STAGES  input register of stage i loads a bubble. flush[0] is always 0.
- `load_pc_we`  out  1  load the PC with `load_pc_target`.
- `load_pc_target`  out  ADDR_WIDTH  redirect target.
- `redirect_pending`  out  1  a blocked redirect is held.
- `cnt_sel`  in  $clog2(2*NUM_STAGES)  counter select.
- `cnt_clear`  in  1  synchronous clear of all counters.
- `cnt_value`  out  CNT_WIDTH  selected counter, registered.
- `wdog_timeout`  out  1  sticky watchdog flag.

## Operation
- **Candidate redirect E.** Take the union of new `redirect_valid[i]` (i≥1) and the pending entry. The highest source index wins (oldest instruction). If a new request has the same index as the pending entry, the new target wins.
- **No E.** stall[N-1]=stall_req[N-1]; stall[i]=stall_req[i]|stall[i+1]. flush[i+1]=stall[i]&~stall[i+1] for i in 0..N-2.
- **E exists, blocked.** E is blocked if stall_req[j] is set for any j≥E.src.
  - stall[i]=1 for i≤E.src.
  - Stages above E.src follow the no-E rule, so flush[E.src+1] is 1 only if stage E.src+1 itself is not stalled.
  - E is written to the pending register. The requester may deassert after this.
- **E exists, fires.** E fires when it is not blocked.
  - load_pc_we=1, load_pc_target=E.target.
  - flush[i]=1 for 1≤i≤E.src; stall[i]=0 for i≤E.src.
  - Pending clears at the edge.
  - stall_req and redirect_valid of stages below E.src are ignored (squashed).
- **Pending.** A lower-index new request does not displace a pending entry.
- **Counters.**
  - Index k<N counts cycles with stall_req[k]=1.
  - Index N+k counts redirects fired from stage k.
  - Counters saturate at all-ones. cnt_clear has priority over increment.
  - cnt_sel ≥ 2N reads 0.
- **Watchdog.** Counts consecutive cycles with stall[0]=1 and load_pc_we=0; any other cycle resets it to 0. When the count reaches WDOG_LIMIT, wdog_timeout is set and stays set until reset.

## Timing
- stall, flush, load_pc_we, load_pc_target and redirect_pending are combinational from the inputs and state, valid in the same cycle.
- Pending register, counters, watchdog and cnt_value update on the rising edge of `clk`.
- cnt_value has 1-cycle latency from cnt_sel.
- Reset clears pending, counters, watchdog count, wdog_timeout and cnt_value to 0. With all inputs 0, every output is 0.
- Reset asserted while a redirect is pending discards it; no PC load follows deassertion.
- A blocked redirect fires in the first cycle all stall_req[j≥src] are clear. It fires exactly once.

## Structure
- Package `hazard_pkg`:
  - `redirect_t` struct {valid, src [$clog2(NUM_STAGES)], target [ADDR_WIDTH]}.
  - Counter index encoding helper.
- Sub-module `hazard_event_counters`: counter bank, saturation, clear and registered read mux.
- Top level holds the resolution logic, pending register and watchdog.

## Test plan
All scenarios use N=5.
1. stall_req=00001 (IF miss) -> stall=00001, flush=00010, load_pc_we=0.
2. stall_req=01000 (stage 3) -> stall=01111, flush=10000.
3. redirect_valid[2], target 0x400, stall_req=00001 -> load_pc_we=1, target 0x400, flush=00110, stall=00000.
4. Two redirects plus pending:
   - redirect_valid[1]=0x100 and redirect_valid[2]=0x200 with stall_req[3]=1 -> pending src 2.
   - Next cycle redirect_valid[1] alone -> pending unchanged.
   - redirect_valid[3]=0x300 arrives -> replaces pending once stage 3 is unblocked.
   - Release -> fires 0x300 once, flush=01110.
5. redirect_valid[2]=0x400 one cycle while stall_req[3]=1 for 3 cycles -> redirect_pending=1 and stall=01111 for 3 cycles. Fires 0x400 in cycle 4; pending 0 in cycle 5. Repeat with rst_n pulsed in cycle 2 -> no PC load afterwards.
6. WDOG_LIMIT=8, stall_req[0]=1 for 8 cycles -> wdog_timeout=1 after the 8th edge and stays set. cnt_sel=0 reads 8, then cnt_clear -> 0. cnt_sel=7 after test 3 reads 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard arbiter.
// Struct fields are sized for the largest supported configuration.
package hazard_pkg;

  localparam int HZ_SRC_W  = 8;
  localparam int HZ_ADDR_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [HZ_SRC_W-1:0]  src;
    logic [HZ_ADDR_W-1:0] target;
  } redirect_t;

  // Counter bank layout: stall counters first, then redirect counters.
  function automatic int cnt_idx(
    input int   num_stages,
    input logic is_redirect,
    input int   stage
  );
    return is_redirect ? num_stages + stage : stage;
  endfunction

endpackage

// File: rtl/hazard_event_counters.sv
// Saturating hazard event counters with synchronous clear.
// Read value is registered one cycle behind the select.
module hazard_event_counters
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_STAGES-1:0]             i_stall_evt,
  input  logic [NUM_STAGES-1:0]             i_fire_evt,
  input  logic [$clog2(2*NUM_STAGES)-1:0]   i_sel,
  input  logic                              i_clear,
  output logic [CNT_WIDTH-1:0]              o_value
);

  localparam int NC = 2 * NUM_STAGES;

  logic [NC-1:0]        w_evt;
  logic [CNT_WIDTH-1:0] r_cnt [NC];
  logic [CNT_WIDTH-1:0] r_value;

  // Map stall and redirect events onto the counter layout.
  always_comb begin
    w_evt = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_evt[cnt_idx(NUM_STAGES, 1'b0, k)] = i_stall_evt[k];
      w_evt[cnt_idx(NUM_STAGES, 1'b1, k)] = i_fire_evt[k];
    end
  end

  // Count, saturate, clear, and register the selected value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) r_cnt[k] <= '0;
      r_value <= '0;
    end else begin
      r_value <= (int'(i_sel) < NC) ? r_cnt[i_sel] : '0;
      for (int k = 0; k < NC; k++) begin
        if (i_clear) begin
          r_cnt[k] <= '0;
        end else if (w_evt[k] && (r_cnt[k] != '1)) begin
          r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/pipeline_hazard_arbiter.sv
// Resolves stage stalls and PC redirects into stall/flush/PC-load.
// Holds one blocked redirect; runs a front-end stall watchdog.
module pipeline_hazard_arbiter
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_STAGES-1:0]            stall_req,
  input  logic [NUM_STAGES-1:0]            redirect_valid,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] redirect_target,
  output logic [NUM_STAGES-1:0]            stall,
  output logic [NUM_STAGES-1:0]            flush,
  output logic                             load_pc_we,
  output logic [ADDR_WIDTH-1:0]            load_pc_target,
  output logic                             redirect_pending,
  input  logic [$clog2(2*NUM_STAGES)-1:0]  cnt_sel,
  input  logic                             cnt_clear,
  output logic [CNT_WIDTH-1:0]             cnt_value,
  output logic                             wdog_timeout
);

  localparam int N    = NUM_STAGES;
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  redirect_t       r_pend;
  redirect_t       w_new;
  redirect_t       w_e;
  logic            w_blocked;
  logic            w_fire;
  logic [N-1:0]    w_chain;
  logic [N-1:0]    w_fire_evt;
  logic            w_wd_run;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wd_to;
  logic            w_unused;

  // Pick the oldest new request and merge it with the held one.
  always_comb begin
    w_new = '0;
    for (int i = 1; i < N; i++) begin
      if (redirect_valid[i]) begin
        w_new.valid = 1'b1;
        w_new.src   = HZ_SRC_W'(i);
        w_new.target = '0;
        w_new.target[ADDR_WIDTH-1:0] =
          redirect_target[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    if (w_new.valid &&
        (!r_pend.valid || (w_new.src >= r_pend.src))) begin
      w_e = w_new;
    end else begin
      w_e = r_pend;
    end
  end

  // Decide whether the candidate is held back by an older stall.
  always_comb begin
    w_blocked = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (stall_req[j] && (HZ_SRC_W'(j) >= w_e.src)) begin
        w_blocked = 1'b1;
      end
    end
    w_blocked = w_blocked & w_e.valid;
    w_fire    = w_e.valid & ~w_blocked;
  end

  // Build stall/flush vectors from the stall chain and redirect.
  always_comb begin
    w_chain[N-1] = stall_req[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      w_chain[i] = stall_req[i] | w_chain[i+1];
    end
    stall      = w_chain;
    flush      = '0;
    w_fire_evt = '0;
    for (int i = 0; i < N; i++) begin
      if (w_e.valid && (HZ_SRC_W'(i) <= w_e.src)) begin
        stall[i] = ~w_fire;
        if (w_fire && (i != 0)) flush[i] = 1'b1;
      end
      if (w_fire && (HZ_SRC_W'(i) == w_e.src)) begin
        w_fire_evt[i] = 1'b1;
      end
    end
    if (!w_fire) begin
      for (int i = 0; i < N - 1; i++) begin
        flush[i+1] = stall[i] & ~stall[i+1];
      end
    end
  end

  assign load_pc_we       = w_fire;
  assign load_pc_target   = w_e.target[ADDR_WIDTH-1:0];
  assign redirect_pending = w_blocked;
  assign w_wd_run         = stall[0] & ~w_fire;

  // Hold a blocked redirect; drop it once it fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_blocked ? w_e : '0;
    end
  end

  // Count consecutive front-end stalls; trip a sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
      r_wd_to  <= 1'b0;
    end else if (!w_wd_run) begin
      r_wd_cnt <= '0;
    end else begin
      if (r_wd_cnt != WD_W'(WDOG_LIMIT)) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
      if (r_wd_cnt >= WD_W'(WDOG_LIMIT - 1)) begin
        r_wd_to <= 1'b1;
      end
    end
  end

  assign wdog_timeout = r_wd_to;

  hazard_event_counters #(
    .NUM_STAGES (N),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_stall_evt (stall_req),
    .i_fire_evt  (w_fire_evt),
    .i_sel       (cnt_sel),
    .i_clear     (cnt_clear),
    .o_value     (cnt_value)
  );

  assign w_unused = ^{redirect_valid[0],
                      redirect_target[ADDR_WIDTH-1:0],
                      w_e.target[HZ_ADDR_W-1:ADDR_WIDTH]};

endmodule
